// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte-stream loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

    localparam int WORD_W         = 32;
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int LANE_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    // Byte offset of word idx inside the image (idx * 4).
    function automatic logic [17:0] word_byte_offset(input logic [15:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Assembles little-endian bytes into a 32-bit word; lane counter wraps every 4 bytes.
// Latency: a loaded byte is visible on word_o the next cycle, on word_next_o the same cycle.
// Backpressure: none; the parent only pulses load_i on an accepted byte.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                load_i,
    input  logic [7:0]          in_data_i,
    output logic [LANE_W-1:0]   byte_idx_o,
    output logic [WORD_W-1:0]   word_o,
    output logic [WORD_W-1:0]   word_next_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [LANE_W-1:0] lane_q, lane_d;

    // Next word: clear wins over load; a load drops the byte into the current lane.
    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        if (clr_i) begin
            word_d = '0;
            lane_d = '0;
        end else if (load_i) begin
            case (lane_q)
                2'd0:    word_d[7:0]   = in_data_i;
                2'd1:    word_d[15:8]  = in_data_i;
                2'd2:    word_d[23:16] = in_data_i;
                default: word_d[31:24] = in_data_i;
            endcase
            lane_d = lane_q + 2'd1;
        end
    end

    // Word and lane registers; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
            lane_q <= '0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
        end
    end

    assign byte_idx_o  = lane_q;
    assign word_o      = word_q;
    assign word_next_o = word_d;

endmodule

// File: rtl/imem_loader.sv
// Program loader: header (16-bit word count) then LE bytes -> 32-bit imem writes, core held meanwhile.
// Latency: 5 cycles per word (4 bytes + 1 write); 2 + 5N + 1 cycles from HDR0 to the done pulse.
// Backpressure: in_ready low in IDLE/WRITE/DONE/ERR and whenever abort is high; source stalls freely.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DEPTH_WORDS = 64,
    parameter int unsigned BASE_ADDR   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                in_valid_i,
    input  logic [7:0]          in_data_i,
    output logic                in_ready_o,
    output logic                im_we_o,
    output logic [ADDR_W-1:0]   im_waddr_o,
    output logic [WORD_W-1:0]   im_wdata_o,
    output logic                core_hold_o,
    output logic                core_rst_o,
    output logic                done_o,
    output logic                err_o,
    output logic [15:0]         words_loaded_o
);

    state_t              state_q, state_d;
    logic [7:0]          cnt_lo_q, cnt_lo_d;
    logic [15:0]         n_q, n_d;
    logic [15:0]         word_idx_q, word_idx_d;
    logic [15:0]         words_loaded_q, words_loaded_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [WORD_W-1:0]   wdata_q, wdata_d;

    logic                hdr_or_data;
    logic                accepting;
    logic                xfer;
    logic                start_take;
    logic [15:0]         n_hdr;
    logic                n_bad;
    logic                pk_clr;
    logic                pk_load;
    logic [LANE_W-1:0]   byte_idx;
    logic [WORD_W-1:0]   pk_word;
    logic [WORD_W-1:0]   pk_word_next;

    // Byte acceptance: only while consuming header/data, and abort blocks the byte.
    always_comb begin
        hdr_or_data = (state_q == ST_HDR0) || (state_q == ST_HDR1) || (state_q == ST_DATA);
        accepting   = hdr_or_data && !abort_i;
        xfer        = accepting && in_valid_i;
        start_take  = start_i && ((state_q == ST_IDLE) || (state_q == ST_ERR));
        n_hdr       = {in_data_i, cnt_lo_q};
        n_bad       = (n_hdr == 16'd0) || (n_hdr > 16'(DEPTH_WORDS));
        // Lane restarts at 0 for every new image; it wraps naturally between words.
        pk_clr      = start_take || (state_q == ST_HDR1);
        pk_load     = (state_q == ST_DATA) && xfer;
    end

    byte_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (pk_clr),
        .load_i      (pk_load),
        .in_data_i   (in_data_i),
        .byte_idx_o  (byte_idx),
        .word_o      (pk_word),
        .word_next_o (pk_word_next)
    );

    // Loader FSM plus word/address bookkeeping; write address/data are captured on the 4th byte.
    always_comb begin
        state_d        = state_q;
        cnt_lo_d       = cnt_lo_q;
        n_d            = n_q;
        word_idx_d     = word_idx_q;
        words_loaded_d = words_loaded_q;
        waddr_d        = waddr_q;
        wdata_d        = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d        = ST_HDR0;
                    words_loaded_d = '0;
                end
            end
            ST_HDR0: begin
                if (abort_i) begin
                    state_d = ST_ERR;
                end else if (xfer) begin
                    cnt_lo_d = in_data_i;
                    state_d  = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (abort_i) begin
                    state_d = ST_ERR;
                end else if (xfer) begin
                    n_d = n_hdr;
                    if (n_bad) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d    = ST_DATA;
                        word_idx_d = '0;
                    end
                end
            end
            ST_DATA: begin
                if (abort_i) begin
                    state_d = ST_ERR;
                end else if (xfer && (byte_idx == LANE_W'(BYTES_PER_WORD - 1))) begin
                    state_d = ST_WRITE;
                    waddr_d = ADDR_W'(BASE_ADDR) + ADDR_W'(word_byte_offset(word_idx_q));
                    wdata_d = pk_word_next;
                end
            end
            ST_WRITE: begin
                // The write itself is unconditional in this state, abort or not.
                word_idx_d     = word_idx_q + 16'd1;
                words_loaded_d = words_loaded_q + 16'd1;
                if (abort_i) begin
                    state_d = ST_ERR;
                end else if (word_idx_q == n_q - 16'd1) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                if (start_i) begin
                    state_d        = ST_HDR0;
                    words_loaded_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything, including the write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_lo_q       <= '0;
            n_q            <= '0;
            word_idx_q     <= '0;
            words_loaded_q <= '0;
            waddr_q        <= '0;
            wdata_q        <= '0;
        end else begin
            state_q        <= state_d;
            cnt_lo_q       <= cnt_lo_d;
            n_q            <= n_d;
            word_idx_q     <= word_idx_d;
            words_loaded_q <= words_loaded_d;
            waddr_q        <= waddr_d;
            wdata_q        <= wdata_d;
        end
    end

    // The packer's registered word is only needed through word_next_o here.
    logic unused_ok;
    assign unused_ok = ^pk_word;

    assign in_ready_o     = accepting;
    assign im_we_o        = (state_q == ST_WRITE);
    assign im_waddr_o     = waddr_q;
    assign im_wdata_o     = wdata_q;
    assign core_hold_o    = (state_q != ST_IDLE);
    assign core_rst_o     = (state_q == ST_DONE);
    assign done_o         = (state_q == ST_DONE);
    assign err_o          = (state_q == ST_ERR);
    assign words_loaded_o = words_loaded_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Byte-stream program loader: the write side of the instruction memory, which the core only ever reads.
- Accepts a header plus little-endian instruction bytes over a valid/ready byte interface and assembles 32-bit words.
- Writes each word into instruction memory at consecutive byte addresses.
- Holds the core off during loading and pulses a core reset when the image is complete.

Parameters:
- ADDR_W, 32, width of the instruction-memory byte address.
- DEPTH_WORDS, 64, instruction-memory capacity in words; the maximum legal word count.
- BASE_ADDR, 0, byte address of the first word written; must be 4-aligned.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a load; honoured only in IDLE or ERR.
- abort  in  1  cancel the load in progress.
- in_valid  in  1  byte source has a byte.
- in_data  in  8  byte value.
- in_ready  out  1  loader accepts a byte this cycle; transfer = in_valid & in_ready.
- im_we  out  1  instruction-memory write enable, one-cycle pulse per word.
- im_waddr  out  ADDR_W  write byte address.
- im_wdata  out  32  write data.
- core_hold  out  1  core must not fetch or commit while high.
- core_rst  out  1  one-cycle pulse restarting the core (PC to 0) after a good load.
- done  out  1  one-cycle pulse, load completed.
- err  out  1  high while in ERR.
- words_loaded  out  16  words written in the current or last load.

Behaviour:
- Reset: state = IDLE. All outputs are 0: in_ready, im_we, im_waddr, im_wdata, core_hold, core_rst, done, err, words_loaded. Any partial word is discarded. Reset mid-load produces no im_we.
- Stream format: cnt_lo, cnt_hi (16-bit word count N, little-endian), then N×4 data bytes. Each word is assembled little-endian: first byte goes to [7:0], fourth byte to [31:24].
- IDLE: in_ready=0, core_hold=0. On start → HDR0; clear words_loaded.
- HDR0: in_ready=1, core_hold=1. On a transfer, cnt[7:0] ← in_data → HDR1.
- HDR1: in_ready=1. On a transfer, form N = {in_data, cnt[7:0]}.
  - N==0 or N>DEPTH_WORDS → ERR.
  - Otherwise → DATA with byte_idx=0, word_idx=0.
- DATA: in_ready=1. On each transfer, lane byte_idx ← in_data and byte_idx++.
  - A transfer at byte_idx==3 → WRITE.
  - in_valid low stalls indefinitely with no timeout.
- WRITE: in_ready=0, im_we=1 for exactly this cycle.
  - im_waddr = BASE_ADDR + 4*word_idx, computed modulo 2^ADDR_W.
  - im_wdata = assembled word.
  - words_loaded++ and word_idx++.
  - If word_idx==N-1 → DONE, else → DATA with byte_idx=0.
- DONE: core_rst=1, done=1, core_hold=1 for one cycle → IDLE. core_hold falls in the following cycle.
- ERR: err=1, core_hold=1 (a partial image never runs), in_ready=0. Only start leaves ERR (→ HDR0, err cleared next cycle).
- abort in HDR0, HDR1, DATA or WRITE → ERR on the next edge.
  - abort has priority over a same-cycle byte transfer: the byte is not consumed and in_ready is forced to 0 that cycle.
  - A WRITE cycle that coincides with abort still performs its im_we.
- abort in IDLE, DONE or ERR is ignored.
- start in any state other than IDLE or ERR is ignored.
- rst has priority over start and abort.
- Throughput: at best 5 cycles per word (4 byte transfers plus 1 write). Load latency is 2 + 5N + 1 cycles from the HDR0 entry to the done pulse.
- im_waddr and im_wdata are registered and hold their last values outside WRITE.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum: IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR;
  - constants HDR_BYTES=2 and BYTES_PER_WORD=4;
  - the word width, 32.
- One natural sub-module: byte_packer.
  - Ports: clk, rst, clr, load, in_data, byte_idx.
  - Output: the 32-bit word, a 2-bit lane register.
- The FSM and address counter stay in imem_loader.

Test Plan:
- Header 0x02,0x00 then bytes 78 56 34 12 EF BE AD DE, in_valid held high → im_we at addr 0x0 data 0x12345678, then at addr 0x4 data 0xDEADBEEF; done and core_rst pulse once; words_loaded=2; total 13 cycles from HDR0.
- Header 0x00,0x00 → err=1, core_hold stays 1, no im_we. Then start plus a valid 1-word stream → recovers, done pulses.
- Header 0x41,0x00 with DEPTH_WORDS=64 → ERR. Header 0x40,0x00 with 256 bytes → last write at addr 0xFC.
- 1-word load with in_valid toggling every other cycle → same data 0x12345678 written once, 4 byte transfers counted, no extra writes.
- abort asserted on the 3rd data byte of word 1 of a 3-word load → word 0 written, no further im_we, err=1, that byte not accepted (in_ready=0 that cycle).
- rst asserted mid-word → all outputs 0 the next cycle. A subsequent start plus a 1-word load writes the correct word with no residue from the old partial word.
